// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl
// Initiator side of the GPR file. It accepts decoded operand requests from the IDU,
// reads the register file, stalls on RAW/WAW hazards using a busy scoreboard,
// hands captured operands to the EXU (valid/ready) and commits WBU writebacks.
// A writeback to x0 is dropped.
//
// Optional build macro: WB_BYPASS_EN
//   When defined, CHECK forwards a same-cycle writeback (wb_data) into a busy
//   source operand. A matching destination also clears the WAW term. This
//   removes the one-cycle stall that follows a writeback.
//   When undefined, operands come only from rf_rdata*, and a request stalls
//   until the busy bit clears.
module regfile_port_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    // decode request
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [AW-1:0]   dec_rs1,
    input  logic            dec_use_rs1,
    input  logic [AW-1:0]   dec_rs2,
    input  logic            dec_use_rs2,
    input  logic [AW-1:0]   dec_rd,
    input  logic            dec_rd_wen,
    // operand bundle to EXU
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_src1,
    output logic [XLEN-1:0] ex_src2,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_wen,
    // writeback from WBU
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    // register file ports
    output logic [AW-1:0]   rf_raddr1,
    output logic            rf_ren1,
    output logic [AW-1:0]   rf_raddr2,
    output logic            rf_ren2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_wen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t          r_state;
    logic [NREG-1:0] r_busy;

    // latched decode request
    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rs2;
    logic [AW-1:0]   r_rd;
    logic            r_use1;
    logic            r_use2;
    logic            r_rd_wen;

    logic            w_accept;
    logic            w_busy1;
    logic            w_busy2;
    logic            w_busyd;
    logic            w_byp1;
    logic            w_byp2;
    logic            w_bypd;
    logic            w_hazard;
    logic            w_issue;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [NREG-1:0] w_busy_nxt;

    // Handshake and port strobes. These come from registered state and are gated by reset.
    assign dec_ready = (r_state == S_IDLE) && !rst;
    assign wb_ready  = !rst;
    assign w_accept  = dec_valid && dec_ready;

    assign rf_raddr1 = r_rs1;
    assign rf_raddr2 = r_rs2;
    assign rf_ren1   = (r_state == S_CHECK) && r_use1 && !rst;
    assign rf_ren2   = (r_state == S_CHECK) && r_use2 && !rst;

    // The regfile write port is a straight pass-through of the WBU. An x0 write never reaches the array.
    assign rf_waddr  = wb_rd;
    assign rf_wdata  = wb_data;
    assign rf_wen    = wb_valid && (wb_rd != '0) && !rst;

    // Hazard detection and operand selection for the request held in CHECK
    always_comb begin
        w_busy1 = r_use1   && r_busy[r_rs1];
        w_busy2 = r_use2   && r_busy[r_rs2];
        w_busyd = r_rd_wen && r_busy[r_rd];
`ifdef WB_BYPASS_EN
        // A writeback landing this cycle resolves the pending writer right now
        w_byp1  = w_busy1 && rf_wen && (wb_rd == r_rs1);
        w_byp2  = w_busy2 && rf_wen && (wb_rd == r_rs2);
        w_bypd  = w_busyd && rf_wen && (wb_rd == r_rd);
`else
        w_byp1  = 1'b0;
        w_byp2  = 1'b0;
        w_bypd  = 1'b0;
`endif
        w_hazard = (w_busy1 && !w_byp1) || (w_busy2 && !w_byp2) || (w_busyd && !w_bypd);
        w_issue  = (r_state == S_CHECK) && !w_hazard;

        // An unused source yields 0 whatever the regfile returns
        w_op1 = '0;
        if (r_use1) w_op1 = w_byp1 ? wb_data : rf_rdata1;
        w_op2 = '0;
        if (r_use2) w_op2 = w_byp2 ? wb_data : rf_rdata2;
    end

    // Scoreboard next state: a writeback clears, an issue sets, and set wins on the same index.
    // x0 is never busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rf_wen)
            w_busy_nxt[wb_rd] = 1'b0;
        if (w_issue && r_rd_wen && (r_rd != '0))
            w_busy_nxt[r_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Busy scoreboard register
    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    // Control FSM with registered request latch and EXU bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_use1    <= 1'b0;
            r_use2    <= 1'b0;
            r_rd_wen  <= 1'b0;
            ex_valid  <= 1'b0;
            ex_src1   <= '0;
            ex_src2   <= '0;
            ex_rd     <= '0;
            ex_rd_wen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rs1    <= dec_rs1;
                        r_rs2    <= dec_rs2;
                        r_rd     <= dec_rd;
                        r_use1   <= dec_use_rs1;
                        r_use2   <= dec_use_rs2;
                        r_rd_wen <= dec_rd_wen;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A hazard holds us here and re-reads the regfile every cycle
                    if (!w_hazard) begin
                        ex_src1   <= w_op1;
                        ex_src2   <= w_op2;
                        ex_rd     <= r_rd;
                        ex_rd_wen <= r_rd_wen;
                        ex_valid  <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The bundle stays frozen until the EXU takes it
                    if (ex_ready) begin
                        ex_valid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    ex_valid <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl. Stimulus pushes the expected EXU bundle.
// A negedge monitor pops and compares the bundle on every EXU handshake.
// Directed timing and port checks are interleaved with the stimulus.
module tb_regfile_port_ctrl;

    localparam int XLEN = 32;
    localparam int AW   = 5;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            dec_valid, dec_ready;
    logic [AW-1:0]   dec_rs1, dec_rs2, dec_rd;
    logic            dec_use_rs1, dec_use_rs2, dec_rd_wen;
    logic            ex_valid, ex_ready;
    logic [XLEN-1:0] ex_src1, ex_src2;
    logic [AW-1:0]   ex_rd;
    logic            ex_rd_wen;
    logic            wb_valid, wb_ready;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   rf_raddr1, rf_raddr2, rf_waddr;
    logic            rf_ren1, rf_ren2, rf_wen;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, rf_wdata;

    regfile_port_ctrl #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_use_rs1(dec_use_rs1),
        .dec_rs2(dec_rs2), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_raddr1(rf_raddr1), .rf_ren1(rf_ren1),
        .rf_raddr2(rf_raddr2), .rf_ren2(rf_ren2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: reads are combinational, return 0 when disabled, and x0 reads 0
    logic [XLEN-1:0] regs [32];
    logic            preload;

    always_comb begin
        rf_rdata1 = '0;
        rf_rdata2 = '0;
        if (rf_ren1 && rf_raddr1 != '0) rf_rdata1 = regs[rf_raddr1];
        if (rf_ren2 && rf_raddr2 != '0) rf_rdata2 = regs[rf_raddr2];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            regs[1] <= 32'd5;
            regs[2] <= 32'd7;
            regs[6] <= 32'h66;
        end else if (rf_wen) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    typedef struct {
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic [AW-1:0]   rd;
        logic            wen;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every EXU handshake must match the oldest expected bundle
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected actual src1=%h src2=%h rd=%0d wen=%b", ex_src1, ex_src2, ex_rd, ex_rd_wen);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (ex_src1 !== e.s1 || ex_src2 !== e.s2 || ex_rd !== e.rd || ex_rd_wen !== e.wen) begin
                    errors++;
                    $display("FAIL bundle actual src1=%h src2=%h rd=%0d wen=%b required src1=%h src2=%h rd=%0d wen=%b",
                             ex_src1, ex_src2, ex_rd, ex_rd_wen, e.s1, e.s2, e.rd, e.wen);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decode request and hold it until accepted. On return we are in the CHECK cycle.
    task automatic send(input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2, input logic u2,
                        input logic [AW-1:0] rd, input logic w,
                        input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2, input bit push);
        int n;
        exp_t e;
        dec_rs1 = rs1; dec_use_rs1 = u1;
        dec_rs2 = rs2; dec_use_rs2 = u2;
        dec_rd  = rd;  dec_rd_wen  = w;
        dec_valid = 1'b1;
        n = 0;
        while (!dec_ready && n < 64) begin tick(); n++; end
        if (n >= 64) check("send_timeout", {31'd0, dec_ready}, 32'd1);
        if (push) begin
            e.s1 = e1; e.s2 = e2; e.rd = rd; e.wen = w;
            q.push_back(e);
        end
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!dec_ready && n < 64) begin tick(); n++; end
        check("idle_timeout", {31'd0, dec_ready}, 32'd1);
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_rd_wen = 0;
        ex_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hBAD;   // must be ignored while in reset
        tick(); tick();
        // Reset state
        check("rst_dec_ready", {31'd0, dec_ready}, 32'd0);
        check("rst_wb_ready",  {31'd0, wb_ready},  32'd0);
        check("rst_rf_wen",    {31'd0, rf_wen},    32'd0);
        check("rst_ex_valid",  {31'd0, ex_valid},  32'd0);
        check("rst_ex_src1",   ex_src1,            32'd0);
        check("rst_rf_ren1",   {31'd0, rf_ren1},   32'd0);
        wb_valid = 1'b0;
        rst = 1'b0; preload = 1'b0;
        tick();
        check("idle_dec_ready", {31'd0, dec_ready}, 32'd1);
        check("idle_wb_ready",  {31'd0, wb_ready},  32'd1);

        // 1: basic read of x1/x2, two-cycle latency, and busy[3] set
        send(5'd1, 1, 5'd2, 1, 5'd3, 1, 32'd5, 32'd7, 1);
        check("t1_lat_c1", {31'd0, ex_valid}, 32'd0);
        check("t1_ren1",   {31'd0, rf_ren1},  32'd1);
        tick();
        check("t1_lat_c2", {31'd0, ex_valid}, 32'd1);
        wait_idle();
        send(5'd3, 1, 5'd0, 0, 5'd0, 0, 32'h33, 32'd0, 1);
        tick(); tick();
        check("t1_busy3_stall", {31'd0, ex_valid}, 32'd0);
        wb(5'd3, 32'h33);
        wait_idle();

        // 2: RAW stall on x5, released by writeback
        send(5'd0, 0, 5'd0, 0, 5'd5, 1, 32'd0, 32'd0, 1);
        wait_idle();
        send(5'd5, 1, 5'd0, 0, 5'd8, 1, 32'h1234, 32'd0, 1);
        tick(); tick(); tick();
        check("t2_stall", {31'd0, ex_valid}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        tick();
        wb_valid = 1'b0;
        check("t2_wb_plus1", {31'd0, ex_valid}, {31'd0, BYP});
        tick();
        check("t2_wb_plus2", {31'd0, ex_valid}, {31'd0, ~BYP});
        wait_idle();
        wb(5'd8, 32'h88);

        // 3: x0 destination never stalls and x0 writes are dropped
        send(5'd0, 1, 5'd0, 0, 5'd0, 1, 32'd0, 32'd0, 1);
        wait_idle();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
        #1;
        check("t3_x0_rf_wen", {31'd0, rf_wen}, 32'd0);
        tick();
        wb_valid = 1'b0;
        send(5'd0, 1, 5'd1, 1, 5'd0, 1, 32'd0, 32'd5, 1);
        tick();
        check("t3_x0_nostall", {31'd0, ex_valid}, 32'd1);
        wait_idle();

        // 4: EXU back-pressure holds the bundle
        ex_ready = 1'b0;
        send(5'd1, 1, 5'd2, 1, 5'd7, 1, 32'd5, 32'd7, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t4_valid",     {31'd0, ex_valid},  32'd1);
            check("t4_src1",      ex_src1,            32'd5);
            check("t4_src2",      ex_src2,            32'd7);
            check("t4_rd",        {27'd0, ex_rd},     32'd7);
            check("t4_dec_ready", {31'd0, dec_ready}, 32'd0);
            tick();
        end
        ex_ready = 1'b1;
        wait_idle();

        // 5: WAW on x7, then busy[7] is set again by the new writer
        send(5'd0, 0, 5'd0, 0, 5'd7, 1, 32'd0, 32'd0, 1);
        tick(); tick();
        check("t5_waw_stall", {31'd0, ex_valid}, 32'd0);
        wb(5'd7, 32'h77);
        wait_idle();
        send(5'd7, 1, 5'd0, 0, 5'd0, 0, 32'h99, 32'd0, 1);
        tick(); tick();
        check("t5_rebusy_stall", {31'd0, ex_valid}, 32'd0);
        wb(5'd7, 32'h99);
        wait_idle();

        // 6: reset in CHECK drops the request and clears busy
        send(5'd0, 0, 5'd0, 0, 5'd6, 1, 32'd0, 32'd0, 1);
        wait_idle();
        send(5'd6, 1, 5'd0, 0, 5'd0, 0, 32'd0, 32'd0, 0);
        tick();
        check("t6_stall", {31'd0, ex_valid}, 32'd0);
        rst = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'hDEAD;
        #1;
        check("t6_rst_rf_wen",    {31'd0, rf_wen},    32'd0);
        check("t6_rst_rf_ren1",   {31'd0, rf_ren1},   32'd0);
        check("t6_rst_dec_ready", {31'd0, dec_ready}, 32'd0);
        tick();
        rst = 1'b0; wb_valid = 1'b0;
        #1;
        check("t6_ex_valid",  {31'd0, ex_valid},  32'd0);
        check("t6_dec_ready", {31'd0, dec_ready}, 32'd1);
        send(5'd6, 1, 5'd0, 0, 5'd0, 0, 32'h66, 32'd0, 1);
        tick();
        check("t6_busy_clear", {31'd0, ex_valid}, 32'd1);
        wait_idle();

        tick(); tick();
        check("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
